mole_hit_tracker: RTL and testbench



---
 rtl/mole_hit_tracker.sv | 179 +++++++++++++++++
 tb/tb_mole_hit_tracker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_hit_tracker.sv
// mole_hit_tracker
//   Front end of the whack-a-mole game. It synchronizes and debounces the
//   player button and runs the mole LED on/off window. Each press that lands
//   while the mole is lit becomes a hit. Hits collect in a saturating pending
//   counter, which is offered to the register-file write injector over a
//   valid/ready handshake.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   btn_n        raw asynchronous button, 0 = pressed
//   mole_led     1 while the hit window is open
//   hit_pulse    one-cycle strobe per accepted hit
//   score_valid  pending increment is non-zero
//   score_ready  consumer takes score_delta this cycle
//   score_delta  pending increment (whole value moves on a handshake)
//   miss_count   16-bit saturating miss counter; present only with
//                MOLE_MISS_COUNT_EN defined
//
// Optional feature macro: MOLE_MISS_COUNT_EN
module mole_hit_tracker #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ON_CYCLES       = 25000000,
  parameter int OFF_CYCLES      = 25000000,
  parameter int SCORE_W         = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_n,
  output logic               mole_led,
  output logic               hit_pulse,
  output logic               score_valid,
  input  logic               score_ready,
  output logic [SCORE_W-1:0] score_delta
`ifdef MOLE_MISS_COUNT_EN
  ,
  output logic [15:0]        miss_count
`endif
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(TMAX);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]   ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]   OFF_LAST = TW'(OFF_CYCLES - 1);

  typedef enum logic {ST_ON, ST_OFF} state_t;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer. It resets to the released level.
  // ---------------------------------------------------------------------
  logic sync1, sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce. A new level is accepted after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement with the current level. press is registered
  // together with the 1->0 level change, so it is high in the first cycle
  // the debounced level reads 0.
  // ---------------------------------------------------------------------
  logic            db_level;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_level <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt   <= '0;
        db_level <= sync2;
        press    <= db_level; // only the falling edge counts as a press
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Mole window FSM. A press outranks the ON timeout in the same cycle.
  // ---------------------------------------------------------------------
  state_t        state;
  logic [TW-1:0] timer;
  logic          hit, on_to, off_to;

  assign hit    = (state == ST_ON) && press;
  assign on_to  = (state == ST_ON) && (timer == ON_LAST);
  assign off_to = (state == ST_OFF) && (timer == OFF_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_ON;
      timer     <= '0;
      mole_led  <= 1'b1;
      hit_pulse <= 1'b0;
    end else begin
      hit_pulse <= hit;
      case (state)
        ST_ON: begin
          if (hit || on_to) begin
            state    <= ST_OFF;
            timer    <= '0;
            mole_led <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_OFF: begin
          // A press here is a miss. It leaves state and timer alone.
          if (off_to) begin
            state    <= ST_ON;
            timer    <= '0;
            mole_led <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state    <= ST_ON;
          timer    <= '0;
          mole_led <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Pending score. A handshake moves the whole value out. A hit in the same
  // cycle starts the new total at 1, so it is not lost.
  // ---------------------------------------------------------------------
  logic [SCORE_W-1:0] pending;
  logic               handshake;

  assign score_valid = |pending;
  assign score_delta = pending;
  assign handshake   = score_valid && score_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else if (handshake) begin
      pending <= {{(SCORE_W-1){1'b0}}, hit};
    end else if (hit && (pending != {SCORE_W{1'b1}})) begin
      pending <= pending + SCORE_W'(1);
    end
  end

`ifdef MOLE_MISS_COUNT_EN
  // A miss is a press while dark, or an ON timeout that no press overrides.
  logic miss_evt;

  assign miss_evt = ((state == ST_OFF) && press) || (on_to && !press);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_count <= '0;
    end else if (miss_evt && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mole_hit_tracker.sv
module tb_mole_hit_tracker;
  localparam int DB  = 4;
  localparam int ON  = 20;
  localparam int OFF = 10;
  localparam int SW  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          btn_n = 1'b1;
  logic          score_ready = 1'b0;
  logic          mole_led, hit_pulse, score_valid;
  logic [SW-1:0] score_delta;
`ifdef MOLE_MISS_COUNT_EN
  logic [15:0]   miss_count;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_hit_q[$];   // expected hit_pulse cycles
  int exp_xfer_q[$];  // expected score_delta at each handshake

  always #5 clk = ~clk;

  mole_hit_tracker #(
    .DEBOUNCE_CYCLES(DB), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_n(btn_n),
    .mole_led(mole_led), .hit_pulse(hit_pulse), .score_valid(score_valid),
    .score_ready(score_ready), .score_delta(score_delta)
`ifdef MOLE_MISS_COUNT_EN
    , .miss_count(miss_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a hit or a transfer.
  always @(negedge clk) begin
    if (reset_n) begin
      if (hit_pulse) begin
        if (exp_hit_q.size() == 0) chk("unexpected_hit", 64'(cyc), 64'hFFFF);
        else chk("hit_cycle", 64'(cyc), 64'(exp_hit_q.pop_front()));
      end
      if (score_valid && score_ready) begin
        if (exp_xfer_q.size() == 0) chk("unexpected_xfer", 64'(score_delta), 64'hFFFF);
        else chk("xfer_value", 64'(score_delta), 64'(exp_xfer_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // Holds reset across one edge; release lands so that cycle 0 follows.
  task automatic do_reset();
    reset_n     = 1'b0;
    btn_n       = 1'b1;
    score_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_led", 64'(mole_led), 64'd1);
    chk("rst_valid", 64'(score_valid), 64'd0);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic end_test();
    chk("hits_left", 64'(exp_hit_q.size()), 64'd0);
    chk("xfers_left", 64'(exp_xfer_q.size()), 64'd0);
  endtask

  // A clean press whose falling edge is driven in cycle f; the hit shows at f+7.
  task automatic hit_at(input int f);
    run_to(f);
    btn_n = 1'b0;
    exp_hit_q.push_back(f + 7);
    run_to(f + 10);
    btn_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: idle schedule, 20 cycles on and 10 off
    do_reset();
    chk("reset_delta", 64'(score_delta), 64'd0);
    chk("reset_hit", 64'(hit_pulse), 64'd0);
    for (int c = 0; c < 100; c++) begin
      chk("idle_led", 64'(mole_led), 64'((c % 30) < 20));
      chk("idle_valid", 64'(score_valid), 64'd0);
      if (c < 99) tick();
    end
`ifdef MOLE_MISS_COUNT_EN
    chk("idle_miss", 64'(miss_count), 64'd3);
`endif
    end_test();

    // 2: single clean press with score_ready held high
    do_reset();
    run_to(5);
    btn_n = 1'b0;
    score_ready = 1'b1;
    exp_hit_q.push_back(12);
    exp_xfer_q.push_back(1);
    run_to(11);
    chk("t2_led_pre", 64'(mole_led), 64'd1);
    tick();
    chk("t2_led_fall", 64'(mole_led), 64'd0);
    chk("t2_valid", 64'(score_valid), 64'd1);
    chk("t2_delta", 64'(score_delta), 64'd1);
    tick();
    chk("t2_valid_after", 64'(score_valid), 64'd0);
    run_to(20);
    btn_n = 1'b1;
    run_to(21);
    chk("t2_led_off", 64'(mole_led), 64'd0);
    tick();
    chk("t2_led_back", 64'(mole_led), 64'd1);
    score_ready = 1'b0;
    end_test();

    // 3: two-cycle glitches are filtered out
    do_reset();
    for (int g = 0; g < 3; g++) begin
      run_to(2 + 4 * g);
      btn_n = 1'b0;
      run_to(4 + 4 * g);
      btn_n = 1'b1;
    end
    while (cyc < 60) begin
      chk("glitch_led", 64'(mole_led), 64'((cyc % 30) < 20));
      tick();
    end
    chk("glitch_valid", 64'(score_valid), 64'd0);
    end_test();

    // 4: accumulate three hits, then transfer all of them at once
    do_reset();
    hit_at(5);
    chk("t4_delta1", 64'(score_delta), 64'd1);
    hit_at(25);
    chk("t4_delta2", 64'(score_delta), 64'd2);
    hit_at(45);
    chk("t4_delta3", 64'(score_delta), 64'd3);
    score_ready = 1'b1;
    exp_xfer_q.push_back(3);
    tick();
    score_ready = 1'b0;
    chk("t4_valid_after", 64'(score_valid), 64'd0);
    chk("t4_delta_after", 64'(score_delta), 64'd0);
    end_test();

    // 5: a hit lands in the handshake cycle while pending=2
    do_reset();
    hit_at(5);
    hit_at(25);
    run_to(45);
    btn_n = 1'b0;
    exp_hit_q.push_back(52);
    run_to(51);
    score_ready = 1'b1;   // internal hit is in this cycle
    exp_xfer_q.push_back(2);
    tick();
    score_ready = 1'b0;
    chk("t5_valid_carry", 64'(score_valid), 64'd1);
    chk("t5_delta_carry", 64'(score_delta), 64'd1);
    run_to(55);
    btn_n = 1'b1;
    run_to(60);
    end_test();

    // 6a: press while dark is a miss; schedule unaffected
    do_reset();
    run_to(3);
    btn_n = 1'b0;
    exp_hit_q.push_back(10);
    run_to(7);
    btn_n = 1'b1;
    run_to(12);
    btn_n = 1'b0;   // debounced press lands at cycle 18, mole dark
    run_to(16);
    btn_n = 1'b1;
    run_to(19);
    chk("t6_led_dark", 64'(mole_led), 64'd0);
`ifdef MOLE_MISS_COUNT_EN
    chk("t6_miss", 64'(miss_count), 64'd1);
`endif
    tick();
    chk("t6_led_on", 64'(mole_led), 64'd1);
    chk("t6_delta", 64'(score_delta), 64'd1);
    run_to(35);
    chk("t6_led_still_on", 64'(mole_led), 64'd1);
    end_test();

    // 6b: asynchronous reset with pending=3
    do_reset();
    hit_at(5);
    hit_at(25);
    hit_at(45);
    chk("t6b_delta_pre", 64'(score_delta), 64'd3);
    run_to(60);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6b_led", 64'(mole_led), 64'd1);
    chk("t6b_valid", 64'(score_valid), 64'd0);
    chk("t6b_delta", 64'(score_delta), 64'd0);
    chk("t6b_hit", 64'(hit_pulse), 64'd0);
`ifdef MOLE_MISS_COUNT_EN
    chk("t6b_miss", 64'(miss_count), 64'd0);
`endif
    end_test();

    // 7: sixteen hits saturate a 4-bit accumulator at 15
    do_reset();
    for (int k = 0; k < 16; k++) hit_at(5 + 20 * k);
    chk("sat_delta", 64'(score_delta), 64'd15);
    score_ready = 1'b1;
    exp_xfer_q.push_back(15);
    tick();
    score_ready = 1'b0;
    chk("sat_valid_after", 64'(score_valid), 64'd0);
    end_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
